sobel_stream_processor: RTL and testbench
=========================================

# sobel_stream_processor

Streaming 3x3 Sobel edge detector for raster-order greyscale frames of parametrised size and pixel depth. It replaces the fixed 224-wide, memory-polled processor with a valid/ready pixel stream, internal line buffers, backpressure, a frame state machine and a saturated gradient-magnitude output. It sits between the pixel source (memory reader or camera front end) and the result writer.

## Interface
- `IMG_W`, default 224: frame width in pixels, ≥ 3
- `IMG_H`, default 224: frame height in lines, ≥ 3
- `PIX_W`, default 8: pixel bit width
- `THRESH`, default 128: binarisation threshold; used only with `SOBEL_THRESH_EN`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse that arms a frame; honoured only in IDLE
- `in_valid`  in  1  input pixel valid
- `in_ready`  out  1  input pixel accepted when `in_valid && in_ready`
- `in_pix`  in  PIX_W  input pixel, raster order
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accepts
- `out_pix`  out  PIX_W  edge magnitude, or binary 0/all-ones
- `out_last`  out  1  marks the final output pixel of a frame
- `busy`  out  1  high in RUN and DRAIN
- `finished`  out  1  one-cycle pulse when the frame completes

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset enters IDLE.
- IDLE: `start` clears the column/row counters and moves to RUN.
- RUN: accepts pixels. On acceptance of pixel (IMG_H-1, IMG_W-1) the FSM moves to DRAIN.
- DRAIN: `in_ready` is 0. Once the pipeline is empty and the `out_last` beat has been accepted, the FSM pulses `finished` and returns to IDLE.
- `start` in RUN or DRAIN is ignored.
- Line storage: two line buffers of IMG_W × PIX_W hold rows r-1 and r-2. Each accepted pixel shifts one column into the 3x3 window: rows r-2, r-1 and r at columns c-2..c.
- Output image: interior pixels only, (IMG_H-2) × (IMG_W-2) pixels.
  - An output is generated on every accepted pixel with row ≥ 2 and col ≥ 2.
  - That output corresponds to centre (row-1, col-1).
- Arithmetic:
  - gx = (p02 + 2·p12 + p22) - (p00 + 2·p10 + p20), signed, PIX_W+3 bits. gy is the same with rows and columns transposed.
  - mag = |gx| + |gy|, unsigned, PIX_W+3 bits.
  - out_pix = min(mag, 2^PIX_W - 1).
- Column and row counters wrap at IMG_W-1 and IMG_H-1. The window is not cleared at line start; outputs for col < 2 are simply suppressed.
- `out_last` is asserted with the output for centre (IMG_H-2, IMG_W-2).

## Timing
- Two-stage pipeline:
  - S1 registers gx and gy.
  - S2 registers out_pix and out_valid.
- Latency from input acceptance to `out_valid` is 2 cycles when there is no stall.
- Global stall: the pipeline advances when `!out_valid || out_ready`.
  - `in_ready` = advance && state == RUN.
  - `out_pix`, `out_valid` and `out_last` hold stable while `out_valid && !out_ready`.
- Simultaneous last-pixel accept and stall: the FSM still enters DRAIN, and `finished` waits for the downstream to drain.
- Reset values:
  - `in_ready`, `out_valid`, `out_last`, `busy`, `finished` = 0.
  - `out_pix` = 0; counters = 0.
  - Line-buffer contents are don't-care.
- Reset mid-frame aborts the frame immediately. No `finished` pulse is produced.

## Configuration
- `SOBEL_THRESH_EN` defined: out_pix = (mag ≥ THRESH) ? 2^PIX_W - 1 : 0. Latency is unchanged.
- Undefined: saturated magnitude as specified above.

## Structure
- Package `sobel_pkg`:
  - FSM state enum `sobel_state_t` (IDLE, RUN, DRAIN).
  - Gradient width localparam `GRAD_W = PIX_W + 3`.
  - Saturation helper function.
- Sub-module `sobel_line_buffer`:
  - Single-clock RAM of IMG_W × PIX_W.
  - Read-before-write at the column address, enabled by the advance strobe.
  - Instantiated twice.

## Test plan
(All scenarios use IMG_W=8, IMG_H=6, PIX_W=8.)
- Flat frame, all pixels 50, out_ready=1: exactly 24 outputs, all 0; `out_last` on the 24th; `finished` one cycle after it.
- Vertical step, cols 0-3 = 0 and cols 4-7 = 100: each output row is 0,0,255,255,0,0 (gx=400 saturated).
- Horizontal ramp, pix = 10·col: all 24 outputs = 80. With `SOBEL_THRESH_EN` and THRESH=128: all 0.
- Ramp frame with out_ready toggling 1/0 each cycle and random in_valid gaps: output sequence identical to the unstalled run, no lost or duplicated beats, out_pix stable while stalled.
- rst_n low for 1 cycle after 20 accepted pixels, then a fresh `start` and a full flat frame: exactly 24 zero outputs, and no output from the aborted frame.
- `start` pulsed during RUN: ignored; the frame still yields exactly 24 outputs and a single `finished` pulse.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the streaming Sobel edge detector.
package sobel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sobel_state_t;

   // Guard bits on top of the pixel width for signed Sobel sums (GRAD_W = PIX_W + 3)
   localparam int unsigned GRAD_GUARD_W = 3;

   function automatic logic [31:0] sat_u(input logic [31:0] val, input logic [31:0] max_val);
      return (val > max_val) ? max_val : val;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage; combinational read of the old value, write of the new one on the same strobe.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int unsigned DEPTH = 224,
   parameter int unsigned WIDTH = 8,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata_c
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   assign o_rdata_c = r_mem[i_addr];

   always_ff @(posedge clk) begin
      if (i_wr_en) r_mem[i_addr] <= i_wdata;
   end

endmodule

// File: rtl/sobel_stream_processor.sv
// Streaming 3x3 Sobel edge detector with line buffers, global stall and frame FSM.
// Define SOBEL_THRESH_EN for binary output (mag >= THRESH -> all ones).
module sobel_stream_processor
   import sobel_pkg::*;
#(
   parameter int unsigned IMG_W  = 224,
   parameter int unsigned IMG_H  = 224,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned THRESH = 128
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pix,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pix,
   output logic             out_last,
   output logic             busy,
   output logic             finished
);

   localparam int unsigned GRAD_W = PIX_W + GRAD_GUARD_W;
   localparam int unsigned COL_W  = $clog2(IMG_W);
   localparam int unsigned ROW_W  = $clog2(IMG_H);
   localparam logic [PIX_W-1:0] PIX_MAX = '1;

   if (IMG_W < 3 || IMG_H < 3 || THRESH > ((1 << GRAD_W) - 1)) begin : g_param_check
      $error("sobel_stream_processor: invalid parameter set");
   end

   sobel_state_t              r_state;
   logic [COL_W-1:0]          r_col;
   logic [ROW_W-1:0]          r_row;
   logic [PIX_W-1:0]          r_cols [3][2];
   logic signed [GRAD_W-1:0]  r_gx, r_gy;
   logic                      r_s1_valid, r_s1_last;
   logic [PIX_W-1:0]          r_out_pix;
   logic                      r_out_valid, r_out_last, r_busy, r_finished;

   logic                      w_adv, w_accept, w_col_end, w_row_end, w_gen;
   logic [PIX_W-1:0]          w_lb1, w_lb2;
   logic [PIX_W-1:0]          w_n [3][3];
   logic signed [GRAD_W-1:0]  w_gx, w_gy;
   logic [GRAD_W-1:0]         w_mag;
   logic [PIX_W-1:0]          w_res;

   function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
      return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
   endfunction

   function automatic logic [GRAD_W-1:0] absv(input logic signed [GRAD_W-1:0] v);
      return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   assign w_adv     = !r_out_valid || out_ready;
   assign in_ready  = w_adv && (r_state == ST_RUN);
   assign w_accept  = in_valid && in_ready;
   assign w_col_end = (r_col == COL_W'(IMG_W - 1));
   assign w_row_end = (r_row == ROW_W'(IMG_H - 1));
   assign w_gen     = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

   // lb1 holds row r-1, lb2 holds row r-2; lb1's old value cascades into lb2
   sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb1 (
      .clk(clk), .i_wr_en(w_accept), .i_addr(r_col), .i_wdata(in_pix), .o_rdata_c(w_lb1)
   );
   sobel_line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(COL_W)) u_lb2 (
      .clk(clk), .i_wr_en(w_accept), .i_addr(r_col), .i_wdata(w_lb1), .o_rdata_c(w_lb2)
   );

   // Window as it stands once the incoming column is shifted in: [row r-2..r][col c-2..c]
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         w_n[i][0] = r_cols[i][0];
         w_n[i][1] = r_cols[i][1];
      end
      w_n[0][2] = w_lb2;
      w_n[1][2] = w_lb1;
      w_n[2][2] = in_pix;
   end

   assign w_gx  = $signed(wsum(w_n[0][2], w_n[1][2], w_n[2][2]) - wsum(w_n[0][0], w_n[1][0], w_n[2][0]));
   assign w_gy  = $signed(wsum(w_n[2][0], w_n[2][1], w_n[2][2]) - wsum(w_n[0][0], w_n[0][1], w_n[0][2]));
   assign w_mag = absv(r_gx) + absv(r_gy);

`ifdef SOBEL_THRESH_EN
   assign w_res = (w_mag >= GRAD_W'(THRESH)) ? PIX_MAX : '0;
`else
   assign w_res = PIX_W'(sat_u(32'(w_mag), 32'(PIX_MAX)));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_col       <= '0;
         r_row       <= '0;
         r_busy      <= 1'b0;
         r_finished  <= 1'b0;
         r_gx        <= '0;
         r_gy        <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_out_pix   <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            r_cols[i][0] <= '0;
            r_cols[i][1] <= '0;
         end
      end else begin
         r_finished <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_col   <= '0;
                  r_row   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_accept && w_col_end && w_row_end) r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               // Last output is only ever in S2 with S1 already empty
               if (r_out_valid && out_ready && r_out_last) begin
                  r_busy     <= 1'b0;
                  r_finished <= 1'b1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase

         if (w_accept) begin
            r_col <= w_col_end ? '0 : r_col + COL_W'(1);
            if (w_col_end) r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            for (int i = 0; i < 3; i++) begin
               r_cols[i][0] <= w_n[i][1];
               r_cols[i][1] <= w_n[i][2];
            end
         end

         if (w_adv) begin
            r_s1_valid  <= w_gen;
            r_s1_last   <= w_gen && w_col_end && w_row_end;
            r_gx        <= w_gx;
            r_gy        <= w_gy;
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            if (r_s1_valid) r_out_pix <= w_res;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_pix   = r_out_pix;
   assign out_last  = r_out_last;
   assign busy      = r_busy;
   assign finished  = r_finished;

endmodule

// File: tb/tb_sobel_stream_processor.sv
// Directed self-checking bench for sobel_stream_processor on an 8x6 frame.
module tb_sobel_stream_processor;

   localparam int IMG_W = 8;
   localparam int IMG_H = 6;
   localparam int NPIX  = IMG_W * IMG_H;
   localparam int NOUT  = (IMG_W - 2) * (IMG_H - 2);
   localparam int TMO   = 1500;
`ifdef SOBEL_THRESH_EN
   localparam int RAMP_EXP = 0;
`else
   localparam int RAMP_EXP = 80;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_pix = 8'd0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_pix;
   logic       out_last;
   logic       busy;
   logic       finished;

   int         total = 0;
   int         bad = 0;
   int         n_acc;
   int         fin_cnt;
   logic       hold_pend;
   logic       last_prev;
   logic [7:0] hold_pix;
   logic       hold_last;
   logic [7:0] q_pix[$];
   logic       q_last[$];

   sobel_stream_processor #(.IMG_W(8), .IMG_H(6), .PIX_W(8), .THRESH(128)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_pix(in_pix), .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
      .out_last(out_last), .busy(busy), .finished(finished)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pix_of(input int mode, input int idx);
      int c;
      c = idx % IMG_W;
      case (mode)
         0:       return 8'd50;
         1:       return (c >= 4) ? 8'd100 : 8'd0;
         default: return 8'(10 * c);
      endcase
   endfunction

   function automatic int exp_of(input int mode, input int k);
      int j;
      j = k % (IMG_W - 2);
      case (mode)
         0:       return 0;
         1:       return (j == 2 || j == 3) ? 255 : 0;
         default: return RAMP_EXP;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // One negedge sample: acceptance count, stall stability, finished timing, output capture
   task automatic sample();
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      if (hold_pend) begin
         total++;
         assert ({out_valid, out_last, out_pix} === {1'b1, hold_last, hold_pix}) else begin
            bad++;
            $error("FAIL stall_hold observed=%b/%b/%0d expected=1/%b/%0d",
                   out_valid, out_last, out_pix, hold_last, hold_pix);
         end
      end
      hold_pend = out_valid && !out_ready;
      hold_pix  = out_pix;
      hold_last = out_last;
      if (finished) begin
         fin_cnt++;
         chk("finished_after_last", 32'(last_prev), 32'd1);
      end
      last_prev = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
         q_pix.push_back(out_pix);
         q_last.push_back(out_last);
      end
   endtask

   task automatic run_frame(input int mode, input bit stall, input bit gaps, input bit mid_start,
                            input int limit);
      int cyc;
      n_acc = 0; fin_cnt = 0; hold_pend = 1'b0; last_prev = 1'b0;
      q_pix.delete(); q_last.delete();
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      sample();
      cyc = 0;
      while (cyc < TMO && !(n_acc >= limit && (limit < NPIX || fin_cnt > 0))) begin
         @(posedge clk); #1;
         start     = mid_start && (n_acc == 10);
         in_valid  = (n_acc < limit) && (!gaps || $urandom_range(0, 2) != 0);
         in_pix    = pix_of(mode, n_acc);
         out_ready = stall ? ~out_ready : 1'b1;
         sample();
         cyc++;
      end
      chk("frame_timeout", 32'(cyc < TMO), 32'd1);
      if (limit == NPIX) begin
         for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            sample();
         end
      end
   endtask

   task automatic check_frame(input int mode, input string tag);
      chk($sformatf("%s_count", tag), 32'(q_pix.size()), 32'(NOUT));
      for (int k = 0; k < NOUT; k++) begin
         if (k < q_pix.size()) begin
            chk($sformatf("%s_pix%0d", tag, k), 32'(q_pix[k]), 32'(exp_of(mode, k)));
            chk($sformatf("%s_last%0d", tag, k), 32'(q_last[k]), 32'(k == NOUT - 1));
         end
      end
      chk($sformatf("%s_finished_cnt", tag), 32'(fin_cnt), 32'd1);
      chk($sformatf("%s_busy_end", tag), 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_finished", 32'(finished), 32'd0);
      chk("rst_out_pix", 32'(out_pix), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;

      run_frame(0, 1'b0, 1'b0, 1'b0, NPIX);
      check_frame(0, "flat");
      run_frame(1, 1'b0, 1'b0, 1'b0, NPIX);
      check_frame(1, "step");
      run_frame(2, 1'b0, 1'b0, 1'b0, NPIX);
      check_frame(2, "ramp");
      run_frame(2, 1'b1, 1'b1, 1'b0, NPIX);
      check_frame(2, "ramp_stall");

      run_frame(2, 1'b0, 1'b0, 1'b0, 20);
      chk("abort_busy_pre", 32'(busy), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready", 32'(in_ready), 32'd0);
      chk("abort_fin_cnt", 32'(fin_cnt), 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_frame(0, 1'b0, 1'b0, 1'b0, NPIX);
      check_frame(0, "post_abort");

      run_frame(1, 1'b0, 1'b0, 1'b1, NPIX);
      check_frame(1, "mid_start");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
